traffic_phase_sequencer: RTL and testbench

- Upstream stage of traffic_controller. Generates its cur_state[1:0] and en inputs.
- Times each phase of a four-phase junction cycle with parameterised dwell counts.
- Honours a pedestrian request by cutting the current green short, but never below a minimum green time.
- Drives one en pulse per phase change, so the controller re-evaluates only when the phase moves.

---
 rtl/traffic_pkg.sv | 10 +
 rtl/traffic_phase_sequencer_if.sv | 11 +
 rtl/traffic_dwell_cnt.sv | 20 ++
 rtl/traffic_phase_sequencer.sv | 64 ++++++
 tb/tb_traffic_phase_sequencer.sv | 129 ++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: phase codes and helpers shared by the sequencer and traffic_controller
package traffic_pkg;
   localparam logic [1:0] PH_GREEN_NS = 2'b00;
   localparam logic [1:0] PH_AMBER_NS = 2'b01;
   localparam logic [1:0] PH_GREEN_EW = 2'b10;
   localparam logic [1:0] PH_AMBER_EW = 2'b11;
   function automatic logic is_green(input logic [1:0] phase);
      return phase == PH_GREEN_NS || phase == PH_GREEN_EW;
   endfunction
endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// traffic_phase_sequencer_if: run/request inputs and phase outputs of the sequencer
interface traffic_phase_sequencer_if #(parameter int CNT_W = 8);
   logic             run;
   logic             ped_req;
   logic [1:0]       cur_state;
   logic             en;
   logic             ped_ack;
   logic [CNT_W-1:0] elapsed;
   modport master (output run, ped_req, input cur_state, en, ped_ack, elapsed);
   modport slave (input run, ped_req, output cur_state, en, ped_ack, elapsed);
endinterface

// File: rtl/traffic_dwell_cnt.sv
// traffic_dwell_cnt: elapsed-cycle counter with clear, enable and terminal compare against a dwell limit
module traffic_dwell_cnt #(parameter int CNT_W = 8) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] cnt,
   output logic             term
);
   logic [CNT_W-1:0] cnt_d, cnt_q;
   always_comb begin
      cnt_d = en ? (clr ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
      cnt   = cnt_q;
      term  = cnt_q == limit - CNT_W'(1);
   end
   always_ff @(posedge clk or negedge res_n)
      if (!res_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: times the four-phase junction cycle, shortens green on pedestrian request, pulses en per phase change
module traffic_phase_sequencer
   import traffic_pkg::*;
#(
   parameter int T_GREEN     = 20,
   parameter int T_AMBER     = 4,
   parameter int T_MIN_GREEN = 6,
   parameter int CNT_W       = 8
) (
   input logic                      clk,
   input logic                      res_n,
   traffic_phase_sequencer_if.slave bus
);
   localparam logic [CNT_W-1:0] GREEN_W = CNT_W'(T_GREEN);
   localparam logic [CNT_W-1:0] AMBER_W = CNT_W'(T_AMBER);
   localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(T_MIN_GREEN - 1);
   if (T_GREEN < 1 || T_GREEN > 2**CNT_W - 1 || T_AMBER < 1 || T_AMBER > 2**CNT_W - 1 ||
       T_MIN_GREEN < 1 || T_MIN_GREEN > T_GREEN) begin : g_param_chk
      $fatal(1, "traffic_phase_sequencer: illegal dwell parameters");
   end
   logic [1:0]       state_q, state_d;
   logic             pend_q, pend_d, en_q, en_d, ack_q, ack_d;
   logic [CNT_W-1:0] elapsed, limit;
   logic             term, green, adv;
   traffic_dwell_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .res_n (res_n),
      .clr   (adv),
      .en    (bus.run),
      .limit (limit),
      .cnt   (elapsed),
      .term  (term)
   );
   always_ff @(posedge clk or negedge res_n)
      if (!res_n) begin
         state_q <= PH_GREEN_NS;
         pend_q  <= 1'b0;
         en_q    <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         en_q    <= en_d;
         ack_q   <= ack_d;
      end
   always_comb begin
      green = is_green(state_q);
      limit = green ? GREEN_W : AMBER_W;
   end
   // a pending request may end green early, but only once the minimum green has elapsed
   always_comb begin
      adv     = bus.run && (term || (green && pend_q && elapsed >= MIN_M1));
      ack_d   = adv && green && pend_q;
      en_d    = adv;
      state_d = adv ? state_q + 2'd1 : state_q;
      pend_d  = (pend_q || bus.ped_req) && !ack_d;
   end
   always_comb begin
      bus.cur_state = state_q;
      bus.en        = en_q;
      bus.ped_ack   = ack_q;
      bus.elapsed   = elapsed;
   end
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: directed vector table, reset corner case and randomized run against a phase-timing model
module tb_traffic_phase_sequencer;
   logic clk = 1'b0;
   logic res_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   traffic_phase_sequencer_if #(.CNT_W(8)) bus ();
   traffic_phase_sequencer #(.T_GREEN(20), .T_AMBER(4), .T_MIN_GREEN(6), .CNT_W(8)) dut (
      .clk   (clk),
      .res_n (res_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   typedef struct {
      bit run;
      bit ped;
      int n;
      int st;
      int el;
      bit en;
      bit ack;
   } vec_t;
   vec_t vecs[$];
   int   dwell[4] = '{20, 4, 20, 4};
   int   m_ph, m_el;
   bit   m_pend, m_en, m_ack;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_out(input string tag, input int st, input int el, input bit en, input bit ack);
      chk({tag, ".cur_state"}, 32'(bus.cur_state), st);
      chk({tag, ".elapsed"}, 32'(bus.elapsed), el);
      chk({tag, ".en"}, 32'(bus.en), 32'(en));
      chk({tag, ".ped_ack"}, 32'(bus.ped_ack), 32'(ack));
   endtask
   task automatic model_reset();
      m_ph = 0; m_el = 0; m_pend = 0; m_en = 0; m_ack = 0;
   endtask
   // phase length comes from the dwell table; a pending request cuts green once 6 cycles are done
   task automatic model_step(input bit run, input bit ped);
      bit green = (m_ph % 2) == 0;
      bit adv = run && (m_el + 1 == dwell[m_ph] || (green && m_pend && m_el + 1 >= 6));
      m_en = adv;
      m_ack = adv && green && m_pend;
      if (adv) begin
         m_ph = (m_ph + 1) % 4;
         m_el = 0;
      end else if (run) m_el++;
      m_pend = (m_pend || ped) && !m_ack;
   endtask
   task automatic cycle(input bit run, input bit ped);
      bus.run = run;
      bus.ped_req = ped;
      @(posedge clk);
      model_step(run, ped);
      @(negedge clk);
   endtask
   initial begin
      bus.run = 1'b0;
      bus.ped_req = 1'b0;
      model_reset();
      vecs.push_back('{1, 0, 19, 0, 19, 0, 0});
      vecs.push_back('{1, 0, 1, 1, 0, 1, 0});
      vecs.push_back('{1, 0, 3, 1, 3, 0, 0});
      vecs.push_back('{1, 0, 1, 2, 0, 1, 0});
      vecs.push_back('{1, 0, 10, 2, 10, 0, 0});
      vecs.push_back('{1, 1, 1, 2, 11, 0, 0});
      vecs.push_back('{1, 0, 1, 3, 0, 1, 1});
      vecs.push_back('{1, 0, 4, 0, 0, 1, 0});
      vecs.push_back('{1, 0, 2, 0, 2, 0, 0});
      vecs.push_back('{1, 1, 1, 0, 3, 0, 0});
      vecs.push_back('{1, 0, 2, 0, 5, 0, 0});
      vecs.push_back('{1, 0, 1, 1, 0, 1, 1});
      vecs.push_back('{1, 0, 1, 1, 1, 0, 0});
      vecs.push_back('{1, 1, 1, 1, 2, 0, 0});
      vecs.push_back('{1, 0, 2, 2, 0, 1, 0});
      vecs.push_back('{1, 0, 5, 2, 5, 0, 0});
      vecs.push_back('{1, 0, 1, 3, 0, 1, 1});
      vecs.push_back('{1, 0, 4, 0, 0, 1, 0});
      vecs.push_back('{1, 0, 8, 0, 8, 0, 0});
      vecs.push_back('{0, 0, 7, 0, 8, 0, 0});
      vecs.push_back('{1, 0, 11, 0, 19, 0, 0});
      vecs.push_back('{1, 0, 1, 1, 0, 1, 0});
      vecs.push_back('{0, 0, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 0, 3, 1, 3, 0, 0});
      vecs.push_back('{1, 0, 1, 2, 0, 1, 0});
      vecs.push_back('{1, 0, 18, 2, 18, 0, 0});
      vecs.push_back('{1, 1, 1, 2, 19, 0, 0});
      vecs.push_back('{1, 0, 1, 3, 0, 1, 1});
      vecs.push_back('{1, 0, 1, 3, 1, 0, 0});
      vecs.push_back('{0, 1, 1, 3, 1, 0, 0});
      vecs.push_back('{1, 0, 3, 0, 0, 1, 0});
      vecs.push_back('{1, 0, 5, 0, 5, 0, 0});
      vecs.push_back('{1, 0, 1, 1, 0, 1, 1});
      vecs.push_back('{1, 0, 3, 1, 3, 0, 0});
      vecs.push_back('{1, 0, 1, 2, 0, 1, 0});
      vecs.push_back('{1, 0, 19, 2, 19, 0, 0});
      vecs.push_back('{1, 1, 1, 3, 0, 1, 0});
      repeat (3) @(negedge clk);
      chk_out("reset", 0, 0, 0, 0);
      res_n = 1'b1;
      foreach (vecs[i]) begin
         repeat (vecs[i].n) cycle(vecs[i].run, vecs[i].ped);
         chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].el, vecs[i].en, vecs[i].ack);
      end
      // asynchronous reset mid-AMBER_EW with en high and a request pending
      bus.run = 1'b1;
      bus.ped_req = 1'b0;
      #2 res_n = 1'b0;
      #1 chk_out("async_rst", 0, 0, 0, 0);
      model_reset();
      @(negedge clk);
      res_n = 1'b1;
      repeat (19) cycle(1, 0);
      chk_out("post_rst_green", 0, 19, 0, 0);
      cycle(1, 0);
      chk_out("post_rst_adv", 1, 0, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0);
         chk_out("rand", m_ph, m_el, m_en, m_ack);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
